// File: rtl/collatz_pkg.sv
// Shared definitions for the 144-bit Collatz iterator, its sweep controller
// and the host I/O adapter.
package collatz_pkg;

    localparam int ITER_W = 144;
    localparam int OLEN_W = 16;
    localparam int PREC_W = 16;

    localparam logic [OLEN_W-1:0] OLEN_MAX = 16'hffff;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LAUNCH,
        ST_WAIT,
        ST_UPDATE,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/collatz_best_tracker.sv
// Running maximum of one per-seed statistic plus the seed that produced it.
// The first seed after a clear is always taken, later ones only on a strict increase.
module collatz_best_tracker
    import collatz_pkg::*;
#(
    parameter int VAL_W  = OLEN_W,
    parameter int SEED_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              upd,
    input  logic [VAL_W-1:0]  val,
    input  logic [SEED_W-1:0] seed,
    output logic [VAL_W-1:0]  best,
    output logic [SEED_W-1:0] best_seed
);

    logic [VAL_W-1:0]  best_q, best_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic              valid_q, valid_d;

    always_comb begin
        best_d  = best_q;
        seed_d  = seed_q;
        valid_d = valid_q;
        if (clr) begin
            best_d  = '0;
            seed_d  = '0;
            valid_d = 1'b0;
        end else if (upd && (!valid_q || (val > best_q))) begin
            best_d  = val;
            seed_d  = seed;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_q  <= '0;
            seed_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            best_q  <= best_d;
            seed_q  <= seed_d;
            valid_q <= valid_d;
        end
    end

    assign best      = best_q;
    assign best_seed = seed_q;

endmodule

// File: rtl/collatz_sweep_ctrl.sv
// Seed sweep sequencer: launches the Collatz core once per seed and keeps
// running maxima of orbit length and path record.
module collatz_sweep_ctrl
    import collatz_pkg::*;
#(
    parameter int SEED_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEED_W-1:0] cfg_start,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              go,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              core_go,
    output logic [ITER_W-1:0] core_seed,
    input  logic              core_busy,
    input  logic [OLEN_W-1:0] core_orbit_len,
    input  logic [PREC_W-1:0] core_path_rec,
    output logic [OLEN_W-1:0] best_len,
    output logic [SEED_W-1:0] best_len_seed,
    output logic [PREC_W-1:0] best_rec,
    output logic [SEED_W-1:0] best_rec_seed,
    output logic [CNT_W-1:0]  seeds_done,
    output logic              sat
);

    sweep_state_t      state_q, state_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  seeds_done_q, seeds_done_d;
    logic              sat_q, sat_d;
    logic              abort_pend_q, abort_pend_d;
    logic              trk_clr, trk_upd;
    logic              in_busy;

    assign in_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        remaining_d  = remaining_q;
        seeds_done_d = seeds_done_q;
        sat_d        = sat_q;
        abort_pend_d = abort_pend_q | (in_busy & abort);
        trk_clr      = 1'b0;
        trk_upd      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    seed_d       = cfg_start;
                    remaining_d  = cfg_count;
                    seeds_done_d = '0;
                    sat_d        = 1'b0;
                    abort_pend_d = 1'b0;
                    trk_clr      = 1'b1;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((remaining_q == '0) || abort_pend_q || abort) begin
                    state_d = ST_DONE;
                end else if (seed_q == '0) begin
                    // Seed 0 never reaches 1, so it is skipped but still counted.
                    seed_d      = seed_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!core_busy) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                trk_upd      = 1'b1;
                sat_d        = sat_q | (core_orbit_len == OLEN_MAX);
                seeds_done_d = seeds_done_q + 1'b1;
                remaining_d  = remaining_q - 1'b1;
                seed_d       = seed_q + 1'b1;
                state_d      = ST_CHECK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            seed_q       <= '0;
            remaining_q  <= '0;
            seeds_done_q <= '0;
            sat_q        <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            remaining_q  <= remaining_d;
            seeds_done_q <= seeds_done_d;
            sat_q        <= sat_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    collatz_best_tracker #(.VAL_W(OLEN_W), .SEED_W(SEED_W)) u_len_trk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (trk_clr),
        .upd       (trk_upd),
        .val       (core_orbit_len),
        .seed      (seed_q),
        .best      (best_len),
        .best_seed (best_len_seed)
    );

    collatz_best_tracker #(.VAL_W(PREC_W), .SEED_W(SEED_W)) u_rec_trk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (trk_clr),
        .upd       (trk_upd),
        .val       (core_path_rec),
        .seed      (seed_q),
        .best      (best_rec),
        .best_seed (best_rec_seed)
    );

    assign busy       = in_busy;
    assign done       = (state_q == ST_DONE);
    assign core_go    = (state_q == ST_LAUNCH);
    assign core_seed  = {{(ITER_W-SEED_W){1'b0}}, seed_q};
    assign seeds_done = seeds_done_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Bench for collatz_sweep_ctrl: behavioural Collatz core plus a sweep-level
// reference that walks the seed range with plain arithmetic.
module tb_collatz_sweep_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  cfg_start = '0;
    logic [15:0]  cfg_count = '0;
    logic         go = 1'b0;
    logic         abort = 1'b0;
    logic         busy, done, core_go;
    logic [143:0] core_seed;
    logic         core_busy = 1'b0;
    logic [15:0]  core_orbit_len = '0;
    logic [15:0]  core_path_rec = '0;
    logic [15:0]  best_len, best_rec, seeds_done;
    logic [31:0]  best_len_seed, best_rec_seed;
    logic         sat;
    logic [113:0] res;

    int n_cmp = 0;
    int n_bad = 0;

    // Core model knobs: mode 0 = real Collatz, mode 1 = values from tables.
    int          model_mode = 0;
    int          core_lat = 2;
    int          wait_cnt = 0;
    logic [31:0] sat_seed = '0;
    logic [15:0] tbl_len[64];
    logic [15:0] tbl_rec[64];
    logic [31:0] launches[$];
    logic [31:0] exp_launch[$];

    always #5 clk = ~clk;

    collatz_sweep_ctrl #(.SEED_W(32), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_count      (cfg_count),
        .go             (go),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .core_go        (core_go),
        .core_seed      (core_seed),
        .core_busy      (core_busy),
        .core_orbit_len (core_orbit_len),
        .core_path_rec  (core_path_rec),
        .best_len       (best_len),
        .best_len_seed  (best_len_seed),
        .best_rec       (best_rec),
        .best_rec_seed  (best_rec_seed),
        .seeds_done     (seeds_done),
        .sat            (sat)
    );

    assign res = {best_len, best_len_seed, best_rec, best_rec_seed, seeds_done, sat, done};

    function automatic void collatz_ref(input logic [31:0] s, output logic [15:0] len,
                                        output logic [15:0] rec);
        logic [143:0] x, mx;
        int n;
        x = {112'b0, s};
        mx = x;
        n = 0;
        while (x != 144'd1 && n < 65535) begin
            if (x[0]) x = x * 3 + 1;
            else x = x >> 1;
            if (x > mx) mx = x;
            n++;
        end
        len = 16'(n);
        rec = mx[143:128];
    endfunction

    function automatic void model_values(input logic [31:0] s, input int k,
                                         output logic [15:0] l, output logic [15:0] r);
        if (model_mode == 0) begin
            collatz_ref(s, l, r);
            if (s == sat_seed) l = 16'hffff;
        end else begin
            l = tbl_len[k % 64];
            r = tbl_rec[k % 64];
        end
    endfunction

    // Behavioural core: busy from the cycle after core_go for core_lat cycles.
    always @(posedge clk) begin
        logic [15:0] l, r;
        if (!rst_n) begin
            core_busy <= 1'b0;
            wait_cnt  <= 0;
        end else if (core_go) begin
            model_values(core_seed[31:0], launches.size(), l, r);
            launches.push_back(core_seed[31:0]);
            core_orbit_len <= l;
            core_path_rec  <= r;
            core_busy      <= 1'b1;
            wait_cnt       <= core_lat;
        end else if (wait_cnt > 0) begin
            wait_cnt <= wait_cnt - 1;
            if (wait_cnt == 1) core_busy <= 1'b0;
        end
    end

    // Sweep-level reference: earliest seed wins ties, zero seeds skipped but counted.
    function automatic void ref_sweep(input logic [31:0] start, input int count,
                                      output logic [113:0] exp_res);
        logic [31:0] s, bls, brs;
        logic [15:0] bl, br, l, r;
        logic        have, st;
        int          k;
        s = start; bl = '0; br = '0; bls = '0; brs = '0; have = 1'b0; st = 1'b0; k = 0;
        exp_launch.delete();
        for (int i = 0; i < count; i++) begin
            if (s != 32'd0) begin
                model_values(s, k, l, r);
                if (!have || l > bl) begin bl = l; bls = s; end
                if (!have || r > br) begin br = r; brs = s; end
                have = 1'b1;
                if (l == 16'hffff) st = 1'b1;
                exp_launch.push_back(s);
                k++;
            end
            s = s + 32'd1;
        end
        exp_res = {bl, bls, br, brs, 16'(k), st, 1'b1};
    endfunction

    task automatic start_sweep(input logic [31:0] start, input logic [15:0] count);
        launches.delete();
        cfg_start = start;
        cfg_count = count;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done timeout: done=%b, required 1 within %0d cycles", name, done, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, core_go, core_seed, res} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b core_go=%b seed=%h res=%h, required all 0",
                     busy, done, core_go, core_seed, res);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, core_go} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_idle: got busy/done/core_go=%b, required 000", {busy, done, core_go});
        end
    endtask

    task automatic test_sweep_1_10();
        logic [113:0] exp_res;
        model_mode = 0; core_lat = 3;
        ref_sweep(32'd1, 10, exp_res);
        start_sweep(32'd1, 16'd10);
        wait_done(2000, "sweep10");
        n_cmp++;
        if (best_len_seed !== 32'd9) begin
            n_bad++; $display("FAIL sweep10 best_len_seed: got %0d, required 9", best_len_seed);
        end
        n_cmp++;
        if (best_len !== exp_res[113:98]) begin
            n_bad++; $display("FAIL sweep10 best_len: got %0d, required %0d", best_len, exp_res[113:98]);
        end
        n_cmp++;
        if ({best_rec, best_rec_seed} !== {16'd0, 32'd1}) begin
            n_bad++; $display("FAIL sweep10 best_rec/seed: got %0d/%0d, required 0/1", best_rec, best_rec_seed);
        end
        n_cmp++;
        if ({seeds_done, sat, done} !== {16'd10, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL sweep10 seeds_done/sat/done: got %0d/%b/%b, required 10/0/1",
                              seeds_done, sat, done);
        end
        n_cmp++;
        if (launches.size() != 10) begin
            n_bad++; $display("FAIL sweep10 launches: got %0d, required 10", launches.size());
        end
    endtask

    task automatic test_wrap();
        model_mode = 0; core_lat = 1;
        start_sweep(32'hffff_ffff, 16'd3);
        wait_done(5000, "wrap");
        n_cmp++;
        if (launches.size() != 2) begin
            n_bad++; $display("FAIL wrap launch_count: got %0d, required 2", launches.size());
        end else begin
            n_cmp++;
            if (launches[0] !== 32'hffff_ffff || launches[1] !== 32'd1) begin
                n_bad++; $display("FAIL wrap launch_seeds: got %h,%h, required ffffffff,00000001",
                                  launches[0], launches[1]);
            end
        end
        n_cmp++;
        if (seeds_done !== 16'd2) begin
            n_bad++; $display("FAIL wrap seeds_done: got %0d, required 2", seeds_done);
        end
    endtask

    task automatic test_count0();
        start_sweep(32'd7, 16'd0);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_bad++; $display("FAIL count0 cycle1 busy/done: got %b, required 10", {busy, done});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b01) begin
            n_bad++; $display("FAIL count0 cycle2 busy/done: got %b, required 01", {busy, done});
        end
        n_cmp++;
        if (res[113:1] !== '0 || launches.size() != 0) begin
            n_bad++; $display("FAIL count0 results: got res=%h launches=%0d, required 0/0",
                              res[113:1], launches.size());
        end
    endtask

    task automatic test_abort();
        logic [15:0] l27, r27;
        int n;
        model_mode = 0; core_lat = 12;
        collatz_ref(32'd27, l27, r27);
        start_sweep(32'd27, 16'd100);
        n = 0;
        while (core_busy !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (core_busy !== 1'b1) begin
            n_bad++; $display("FAIL abort core_busy: got %b, required 1 within 20 cycles", core_busy);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done(200, "abort");
        n_cmp++;
        if ({seeds_done, best_len, best_len_seed} !== {16'd1, l27, 32'd27}) begin
            n_bad++; $display("FAIL abort results: got done_cnt=%0d len=%0d seed=%0d, required 1/%0d/27",
                              seeds_done, best_len, best_len_seed, l27);
        end
        n_cmp++;
        if (launches.size() != 1) begin
            n_bad++; $display("FAIL abort launches: got %0d, required 1", launches.size());
        end
    endtask

    task automatic test_sat();
        model_mode = 0; core_lat = 2; sat_seed = 32'd5;
        start_sweep(32'd4, 16'd3);
        wait_done(500, "sat");
        n_cmp++;
        if ({sat, best_len, best_len_seed} !== {1'b1, 16'hffff, 32'd5}) begin
            n_bad++; $display("FAIL sat results: got sat=%b len=%h seed=%0d, required 1/ffff/5",
                              sat, best_len, best_len_seed);
        end
        sat_seed = '0;
    endtask

    task automatic test_reset_mid_wait();
        int n;
        model_mode = 0; core_lat = 8;
        start_sweep(32'd27, 16'd5);
        n = 0;
        while (core_busy !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({busy, done, core_go, core_seed, res} !== '0) begin
            n_bad++; $display("FAIL midreset outputs: got busy=%b done=%b core_go=%b res=%h, required all 0",
                              busy, done, core_go, res);
        end
        @(posedge clk); #1;
        core_lat = 2;
        start_sweep(32'd1, 16'd10);
        wait_done(2000, "midreset_resweep");
        n_cmp++;
        if ({best_len_seed, seeds_done} !== {32'd9, 16'd10}) begin
            n_bad++; $display("FAIL midreset resweep: got seed=%0d seeds_done=%0d, required 9/10",
                              best_len_seed, seeds_done);
        end
    endtask

    // Random sweeps with table-driven core results; a go during the sweep must be ignored.
    task automatic test_random();
        logic [113:0] exp_res;
        logic [31:0]  start;
        int           count;
        bit           seeds_ok;
        model_mode = 1;
        for (int it = 0; it < 20; it++) begin
            for (int j = 0; j < 64; j++) begin
                tbl_len[j] = ($urandom_range(0, 15) == 0) ? 16'hffff : 16'($urandom_range(0, 7));
                tbl_rec[j] = 16'($urandom_range(0, 7));
            end
            start = (it % 3 == 0) ? 32'hffff_fffa + 32'($urandom_range(0, 5)) : $urandom;
            count = $urandom_range(0, 12);
            core_lat = $urandom_range(1, 4);
            ref_sweep(start, count, exp_res);
            start_sweep(start, 16'(count));
            cfg_start = $urandom;
            cfg_count = 16'($urandom_range(1, 50));
            go = 1'b1;
            @(posedge clk); #1;
            go = 1'b0;
            wait_done(500, "random");
            n_cmp++;
            if (res !== exp_res) begin
                n_bad++; $display("FAIL random[%0d] results start=%h count=%0d: got %h, required %h",
                                  it, start, count, res, exp_res);
            end
            seeds_ok = (launches.size() == exp_launch.size());
            if (seeds_ok)
                for (int j = 0; j < launches.size(); j++)
                    if (launches[j] !== exp_launch[j]) seeds_ok = 1'b0;
            n_cmp++;
            if (!seeds_ok) begin
                n_bad++; $display("FAIL random[%0d] launch_list: got %0d launches, required %0d",
                                  it, launches.size(), exp_launch.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep_1_10();
        test_wrap();
        test_count0();
        test_abort();
        test_sat();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
